// File: rtl/result_uart_dumper.sv
// Dumps the dmem result area over an 8N1 UART as hex text lines once the core finishes.
// Optional RESULT_DUMP_HEADER_EN prepends an "N=xx\r\n" header line with the area count.
module result_uart_dumper #(
  parameter int CLKS_PER_BIT     = 868,
  parameter int RESULT_BASE_WORD = 256,
  parameter int MAX_AREAS        = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        finish,
  input  logic [31:0] mem_rd,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [7:0]  areas
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CNT  = 3'd1,
    RD_WORD = 3'd2,
    LOAD    = 3'd3,
    TX_BYTE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int          CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  MAX_A    = (MAX_AREAS > 255) ? 8'hFF : 8'(MAX_AREAS);
  localparam logic [15:0] BASE     = 16'(RESULT_BASE_WORD);

  state_t        state_q, state_d;
  logic          finish_q, finish_d;
  logic [7:0]    areas_q, areas_d;
  logic [7:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic [3:0]    char_q, char_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          tx_q, tx_d;
`ifdef RESULT_DUMP_HEADER_EN
  logic          hdr_q, hdr_d;
`endif

  logic [3:0] nib;
  logic [7:0] cur_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Nibble c of the latched word, most significant first.
  assign nib = 4'(word_q >> (5'd28 - {char_q[2:0], 2'b00}));

  always_comb begin
    cur_char = 8'h0A;
    if (char_q < 4'd8)       cur_char = hex_ascii(nib);
    else if (char_q == 4'd8) cur_char = 8'h0D;
`ifdef RESULT_DUMP_HEADER_EN
    if (hdr_q) begin
      case (char_q)
        4'd0:    cur_char = 8'h4E;
        4'd1:    cur_char = 8'h3D;
        4'd2:    cur_char = hex_ascii(areas_q[7:4]);
        4'd3:    cur_char = hex_ascii(areas_q[3:0]);
        4'd4:    cur_char = 8'h0D;
        default: cur_char = 8'h0A;
      endcase
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    finish_d  = finish;
    areas_d   = areas_q;
    idx_d     = idx_q;
    word_d    = word_q;
    char_d    = char_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
`ifdef RESULT_DUMP_HEADER_EN
    hdr_d     = hdr_q;
`endif
    mem_req   = 1'b0;
    mem_addr  = 16'h0000;

    case (state_q)
      IDLE: begin
        if (finish_q) state_d = RD_CNT;
      end
      RD_CNT: begin
        mem_req = 1'b1;
        areas_d = (mem_rd[31:24] > MAX_A) ? MAX_A : mem_rd[31:24];
        idx_d   = 8'd0;
        char_d  = 4'd0;
`ifdef RESULT_DUMP_HEADER_EN
        // Prefetch word 0 even with no areas; keeps first start bit timing identical.
        hdr_d   = 1'b1;
        state_d = RD_WORD;
`else
        state_d = (areas_d == 8'd0) ? DONE : RD_WORD;
`endif
      end
      RD_WORD: begin
        mem_req  = 1'b1;
        mem_addr = BASE + {8'h00, idx_q};
        word_d   = mem_rd;
        char_d   = 4'd0;
        state_d  = LOAD;
      end
      LOAD: begin
        shift_d   = cur_char;
        tx_d      = 1'b0;
        bit_idx_d = 4'd0;
        bit_cnt_d = '0;
        state_d   = TX_BYTE;
      end
      TX_BYTE: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 4'd9) begin
            tx_d = 1'b1;
`ifdef RESULT_DUMP_HEADER_EN
            if (hdr_q) begin
              if (char_q < 4'd5) begin
                char_d  = char_q + 4'd1;
                state_d = LOAD;
              end else begin
                hdr_d   = 1'b0;
                char_d  = 4'd0;
                state_d = (areas_q == 8'd0) ? DONE : LOAD;
              end
            end else
`endif
            if (char_q < 4'd9) begin
              char_d  = char_q + 4'd1;
              state_d = LOAD;
            end else if (({1'b0, idx_q} + 9'd1) < {1'b0, areas_q}) begin
              idx_d   = idx_q + 8'd1;
              state_d = RD_WORD;
            end else begin
              state_d = DONE;
            end
          end else begin
            // Shifting in ones means the stop bit falls out after the 8th data bit.
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b1, shift_q[7:1]};
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        tx_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      finish_q  <= 1'b0;
      areas_q   <= 8'd0;
      idx_q     <= 8'd0;
      word_q    <= 32'd0;
      char_q    <= 4'd0;
      shift_q   <= 8'd0;
      bit_idx_q <= 4'd0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
`ifdef RESULT_DUMP_HEADER_EN
      hdr_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      finish_q  <= finish_d;
      areas_q   <= areas_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      char_q    <= char_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
`ifdef RESULT_DUMP_HEADER_EN
      hdr_q     <= hdr_d;
`endif
    end
  end

  assign tx    = tx_q;
  assign busy  = (state_q != IDLE) && (state_q != DONE);
  assign done  = (state_q == DONE);
  assign areas = areas_q;

endmodule
